// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scan driver with shadowed frame inputs,
// leading-zero blanking, per-digit blink and PWM brightness.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_COUNT    = 208333,
  parameter int BRIGHT_BITS  = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] seg,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int DW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_COUNT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frm_cnt;
  logic                    blink_off;
  logic [BRIGHT_BITS-1:0]  pwm_cnt;

  logic [4*NUM_DIGITS-1:0] sh_seg;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_mask;
  logic                    sh_blz;

  logic                    slot_tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   lz;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic                    blank;
  logic                    on;
  logic                    lit;

  assign slot_tick = (div_cnt == DIV_MAX);
  assign wrap      = slot_tick && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      idx       <= '0;
      frm_cnt   <= '0;
      blink_off <= 1'b0;
      pwm_cnt   <= '0;
      sh_seg    <= '0;
      sh_dp     <= '0;
      sh_mask   <= '0;
      sh_blz    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      div_cnt <= slot_tick ? '0 : div_cnt + 1'b1;
      if (slot_tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        sh_seg  <= seg;
        sh_dp   <= dp;
        sh_mask <= blink_mask;
        sh_blz  <= blank_lz;
        if (frm_cnt == FRM_MAX) begin
          frm_cnt   <= '0;
          blink_off <= ~blink_off;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end
    end
  end

  // lz[k]: nibble k and every nibble above it are zero
  always_comb begin
    logic acc;
    acc = 1'b1;
    lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc   = acc & (sh_seg[4*k +: 4] == 4'h0);
      lz[k] = acc;
    end
  end

  assign nib   = 4'(sh_seg >> {idx, 2'b00});
  assign blank = sh_blz && lz[idx] && (idx != '0);
  assign on    = (&brightness) || (pwm_cnt < brightness);
  assign lit   = on && !blank && !(blink_off && sh_mask[idx]);

  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      AN         <= '1;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (lit) begin
        AN      <= ~(NUM_DIGITS'(1) << idx);
        seg_out <= glyph;
        dp_out  <= ~sh_dp[idx];
      end else begin
        AN      <= '1;
        seg_out <= 7'h7F;
        dp_out  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: a time-indexed
// reference model predicts each cycle's outputs.
module tb_seg7_scan_controller;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int BF = 2;
  localparam int DN = D * N;

  logic        clk;
  logic        reset;
  logic [15:0] seg_i;
  logic [3:0]  dp_i;
  logic [3:0]  mask_i;
  logic        blz_i;
  logic [3:0]  bright_i;
  logic [3:0]  an;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_tick;

  seg7_scan_controller #(
    .NUM_DIGITS(N),
    .DIV_COUNT(D),
    .BRIGHT_BITS(4),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg(seg_i),
    .dp(dp_i),
    .blink_mask(mask_i),
    .blank_lz(blz_i),
    .brightness(bright_i),
    .AN(an),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] so;
    logic       dpo;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int          t;
  logic [15:0] sh_seg;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_mask;
  logic        sh_blz;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Outputs after the next edge, given t edges elapsed since reset
  function automatic exp_t predict(int tt, int br);
    exp_t e;
    int idx, pwm, frames, boff, upper, nibv;
    bit blank, on, lit;
    idx    = (tt / D) % N;
    pwm    = tt % 16;
    frames = tt / DN;
    boff   = (frames / BF) % 2;
    upper  = int'(sh_seg) >> (4 * idx);
    nibv   = upper % 16;
    blank  = sh_blz && idx != 0 && upper == 0;
    on     = (br == 15) || (pwm < br);
    lit    = on && !blank && !(boff == 1 && sh_mask[idx]);
    e.ft   = ((tt % DN) == DN - 1);
    if (lit) begin
      e.an  = 4'hF ^ (4'h1 << idx);
      e.so  = font[nibv];
      e.dpo = ~sh_dp[idx];
    end else begin
      e.an  = 4'hF;
      e.so  = 7'h7F;
      e.dpo = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t       = 0;
      sh_seg  = '0;
      sh_dp   = '0;
      sh_mask = '0;
      sh_blz  = 1'b0;
    end else begin
      q.push_back(predict(t, int'(bright_i)));
      t++;
      if (t % DN == 0) begin
        sh_seg  = seg_i;
        sh_dp   = dp_i;
        sh_mask = mask_i;
        sh_blz  = blz_i;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("AN", int'(an), int'(e.an));
      check("seg_out", int'(seg_out), int'(e.so));
      check("dp_out", int'(dp_out), int'(e.dpo));
      check("frame_tick", int'(frame_tick), int'(e.ft));
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_AN"}, int'(an), 'hF);
    check({tag, "_seg_out"}, int'(seg_out), 'h7F);
    check({tag, "_dp_out"}, int'(dp_out), 1);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  initial begin
    reset    = 1'b0;
    seg_i    = 16'h1234;
    dp_i     = 4'h0;
    mask_i   = 4'h0;
    blz_i    = 1'b0;
    bright_i = 4'hF;
    run(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    run(64);
    seg_i = 16'h0050;
    blz_i = 1'b1;
    dp_i  = 4'b0100;
    run(48);
    seg_i = 16'h0000;
    run(48);
    seg_i  = 16'h1234;
    blz_i  = 1'b0;
    dp_i   = 4'h0;
    mask_i = 4'b0001;
    run(128);
    mask_i   = 4'h0;
    bright_i = 4'd4;
    run(64);
    bright_i = 4'd0;
    run(32);
    bright_i = 4'hF;
    repeat (1500) begin
      @(negedge clk);
      case ($urandom_range(0, 15))
        0: seg_i = 16'($urandom);
        1: seg_i = 16'($urandom_range(0, 255));
        2: dp_i = 4'($urandom);
        3: mask_i = 4'($urandom);
        4: blz_i = 1'($urandom);
        5: bright_i = 4'($urandom_range(0, 15));
        6: bright_i = 4'hF;
        default: ;
      endcase
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midslot_reset");
    run(3);
    check_reset_outputs("held_reset");
    reset = 1'b1;
    run(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
